// File: rtl/cp0_pkg.sv
// Shared definitions for coprocessor 0 of the pipelined MIPS core.
// Holds the CP0 register numbers, the bit positions of the SR and Cause
// fields, the exception codes carried down the pipeline and the handler
// entry address. The PC mux uses the handler address; cp0 itself does not.
package cp0_pkg;

    // Register numbers, taken from the rd field of mfc0/mtc0
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // SR field positions
    localparam int SR_IM_HI  = 15;
    localparam int SR_IM_LO  = 10;
    localparam int SR_EXL    = 1;
    localparam int SR_IE     = 0;

    // Cause field positions
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_EXC_LO = 2;

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Exception/interrupt handler entry point
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    // Clears the two low bits of an EPC value when alignment is enabled
    function automatic logic [31:0] align_epc(input logic [31:0] pc, input bit do_align);
        return do_align ? {pc[31:2], 2'b00} : pc;
    endfunction

endpackage

// File: rtl/cp0.sv
// Coprocessor 0 for the pipelined MIPS core, placed at the M stage.
// Decides whether an interrupt or exception is taken this cycle, records
// the victim PC, branch-delay flag and cause, supplies EPC for eret and
// implements the mfc0/mtc0 register file (SR, Cause, EPC, PRId).
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   cp0_addr     mfc0/mtc0 register number
//   cp0_wdata    mtc0 write data
//   cp0_we       mtc0 at M stage
//   cp0_rdata    combinational read of the register at cp0_addr
//   vpc          M-stage PC (victim PC)
//   bd_in        M-stage instruction sits in a branch delay slot
//   exc_code_in  pipeline exception code, 0 means none
//   hw_int       hardware interrupt lines (level-sensitive)
//   eret         eret at M stage
//   req          take interrupt/exception this cycle
//   epc_out      current EPC, or forwarded mtc0 data targeting EPC
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h4D49_5053,
    parameter bit          EPC_ALIGN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic        cp0_we,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        take;
    logic        mtc0_ok;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] victim_epc;

    // Request decision. EXL masks both sources while the handler runs, and
    // the whole request is held off while reset is asserted so that req is
    // 0 even before the first reset edge has cleared the registers.
    always_comb begin
        int_req    = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
        exc_req    = (exc_code_in != 5'd0) & ~sr_exl;
        take       = (int_req | exc_req) & ~reset;
        mtc0_ok    = cp0_we & ~take;
        victim_epc = align_epc(bd_in ? (vpc - 32'd4) : vpc, EPC_ALIGN);
    end

    assign req = take;

    // Packed views of SR and Cause with reserved bits reading as 0
    always_comb begin
        sr_word                      = 32'd0;
        sr_word[SR_IM_HI:SR_IM_LO]   = sr_im;
        sr_word[SR_EXL]              = sr_exl;
        sr_word[SR_IE]               = sr_ie;
        cause_word                          = 32'd0;
        cause_word[CAUSE_BD]                = cause_bd;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO] = cause_ip;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
    end

    // Read port returns stored (pre-write) state; PRId is constant and is
    // the only value visible while reset is held.
    always_comb begin
        cp0_rdata = 32'd0;
        unique case (cp0_addr)
            REG_SR:    cp0_rdata = reset ? 32'd0 : sr_word;
            REG_CAUSE: cp0_rdata = reset ? 32'd0 : cause_word;
            REG_EPC:   cp0_rdata = reset ? 32'd0 : epc;
            REG_PRID:  cp0_rdata = PRID_VALUE;
            default:   cp0_rdata = 32'd0;
        endcase
    end

    // EPC output for the eret redirect. An mtc0 to EPC in the same cycle is
    // forwarded so a back-to-back mtc0/eret pair returns to the new address.
    always_comb begin
        epc_out = epc;
        if (reset)
            epc_out = 32'd0;
        else if (mtc0_ok && cp0_addr == REG_EPC)
            epc_out = align_epc(cp0_wdata, EPC_ALIGN);
    end

    // SR update. A taken request wins over mtc0 and eret; otherwise mtc0
    // writes the fields first and a simultaneous eret then clears EXL.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im  <= 6'd0;
            sr_exl <= 1'b0;
            sr_ie  <= 1'b0;
        end else if (take) begin
            sr_exl <= 1'b1;
        end else begin
            if (mtc0_ok && cp0_addr == REG_SR) begin
                sr_im  <= cp0_wdata[SR_IM_HI:SR_IM_LO];
                sr_exl <= cp0_wdata[SR_EXL];
                sr_ie  <= cp0_wdata[SR_IE];
            end
            if (eret)
                sr_exl <= 1'b0;
        end
    end

    // Cause update. IP tracks the interrupt lines every cycle; BD and
    // ExcCode only change when a request is taken. Software cannot write it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
        end else begin
            cause_ip <= hw_int;
            if (take) begin
                cause_bd  <= bd_in;
                cause_exc <= int_req ? EXC_INT : exc_code_in;
            end
        end
    end

    // EPC update. The victim PC points at the branch when the faulting
    // instruction is in a delay slot, so the branch is re-executed on eret.
    always_ff @(posedge clk) begin
        if (reset)
            epc <= 32'd0;
        else if (take)
            epc <= victim_epc;
        else if (mtc0_ok && cp0_addr == REG_EPC)
            epc <= align_epc(cp0_wdata, EPC_ALIGN);
    end

endmodule

// File: tb/tb_cp0.sv
// Directed testbench for cp0. Inputs change 1 time unit after the rising
// edge and outputs are checked 1 time unit after that, well clear of edges.
module tb_cp0;

    logic        clk;
    logic        reset;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        cp0_we;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    int vectors;
    int miscompares;
    logic [31:0] rd;

    cp0 #(.PRID_VALUE(32'h4D49_5053), .EPC_ALIGN(1'b1)) dut (
        .clk(clk),
        .reset(reset),
        .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata),
        .cp0_we(cp0_we),
        .cp0_rdata(cp0_rdata),
        .vpc(vpc),
        .bd_in(bd_in),
        .exc_code_in(exc_code_in),
        .hw_int(hw_int),
        .eret(eret),
        .req(req),
        .epc_out(epc_out)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 unit past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Combinational register read (only used while cp0_we is 0)
    task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
        cp0_addr = a;
        #1;
        d = cp0_rdata;
    endtask

    // Single-cycle mtc0, completed at the next edge
    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1'b1;
        cp0_addr = a;
        cp0_wdata = d;
        tick();
        cp0_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        #1;
        vectors++;
        if (req !== 1'b0 || epc_out !== 32'd0) begin
            $display("[TB] FAIL reset_hold_outputs: req=%b epc_out=%h required req=0 epc_out=0", req, epc_out);
            miscompares++;
        end
        tick();
        reset = 1'b0;
        read_reg(5'd12, rd);
        vectors++;
        if (rd !== 32'd0) begin
            $display("[TB] FAIL reset_sr: got %h required 00000000", rd);
            miscompares++;
        end
        read_reg(5'd13, rd);
        vectors++;
        if (rd !== 32'd0) begin
            $display("[TB] FAIL reset_cause: got %h required 00000000", rd);
            miscompares++;
        end
        read_reg(5'd14, rd);
        vectors++;
        if (rd !== 32'd0) begin
            $display("[TB] FAIL reset_epc: got %h required 00000000", rd);
            miscompares++;
        end
        read_reg(5'd15, rd);
        vectors++;
        if (rd !== 32'h4D49_5053) begin
            $display("[TB] FAIL reset_prid: got %h required 4d495053", rd);
            miscompares++;
        end
        vectors++;
        if (req !== 1'b0) begin
            $display("[TB] FAIL reset_req: got %b required 0", req);
            miscompares++;
        end
    endtask

    task automatic test_interrupt();
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        vpc = 32'h0000_3010;
        bd_in = 1'b0;
        #1;
        vectors++;
        if (req !== 1'b1) begin
            $display("[TB] FAIL int_req_same_cycle: got %b required 1", req);
            miscompares++;
        end
        tick();
        read_reg(5'd14, rd);
        vectors++;
        if (rd !== 32'h0000_3010) begin
            $display("[TB] FAIL int_epc: got %h required 00003010", rd);
            miscompares++;
        end
        read_reg(5'd13, rd);
        vectors++;
        if (rd !== 32'h0000_0400) begin
            $display("[TB] FAIL int_cause: got %h required 00000400", rd);
            miscompares++;
        end
        read_reg(5'd12, rd);
        vectors++;
        if (rd !== 32'h0000_0403) begin
            $display("[TB] FAIL int_sr_exl: got %h required 00000403", rd);
            miscompares++;
        end
        vectors++;
        if (req !== 1'b0) begin
            $display("[TB] FAIL int_exl_masks: got req=%b required 0", req);
            miscompares++;
        end
        hw_int = 6'b000000;
        mtc0(5'd12, 32'h0000_0000);
    endtask

    task automatic test_exception_bd();
        exc_code_in = 5'd12;
        bd_in = 1'b1;
        vpc = 32'h0000_3024;
        #1;
        vectors++;
        if (req !== 1'b1) begin
            $display("[TB] FAIL exc_req: got %b required 1", req);
            miscompares++;
        end
        tick();
        exc_code_in = 5'd0;
        bd_in = 1'b0;
        read_reg(5'd14, rd);
        vectors++;
        if (rd !== 32'h0000_3020) begin
            $display("[TB] FAIL exc_bd_epc: got %h required 00003020", rd);
            miscompares++;
        end
        read_reg(5'd13, rd);
        vectors++;
        if (rd !== 32'h8000_0030) begin
            $display("[TB] FAIL exc_cause: got %h required 80000030", rd);
            miscompares++;
        end
        read_reg(5'd12, rd);
        vectors++;
        if (rd !== 32'h0000_0002) begin
            $display("[TB] FAIL exc_sr: got %h required 00000002", rd);
            miscompares++;
        end
    endtask

    task automatic test_eret();
        // IM for hw_int[2], EXL and IE all set; the pending line stays masked
        mtc0(5'd12, 32'h0000_1003);
        hw_int = 6'b000100;
        #1;
        vectors++;
        if (req !== 1'b0) begin
            $display("[TB] FAIL eret_pending_masked: got req=%b required 0", req);
            miscompares++;
        end
        eret = 1'b1;
        #1;
        vectors++;
        if (epc_out !== 32'h0000_3020) begin
            $display("[TB] FAIL eret_epc_out: got %h required 00003020", epc_out);
            miscompares++;
        end
        tick();
        eret = 1'b0;
        vpc = 32'h0000_3030;
        read_reg(5'd12, rd);
        vectors++;
        if (rd !== 32'h0000_1001) begin
            $display("[TB] FAIL eret_exl_clear: got %h required 00001001", rd);
            miscompares++;
        end
        vectors++;
        if (req !== 1'b1) begin
            $display("[TB] FAIL eret_pending_req: got %b required 1", req);
            miscompares++;
        end
        tick();
        read_reg(5'd14, rd);
        vectors++;
        if (rd !== 32'h0000_3030) begin
            $display("[TB] FAIL eret_reentry_epc: got %h required 00003030", rd);
            miscompares++;
        end
        hw_int = 6'b000000;
        mtc0(5'd12, 32'h0000_0000);
    endtask

    task automatic test_priority();
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        vpc = 32'h0000_3040;
        exc_code_in = 5'd10;
        cp0_we = 1'b1;
        cp0_addr = 5'd14;
        cp0_wdata = 32'hDEAD_0000;
        #1;
        vectors++;
        if (req !== 1'b1) begin
            $display("[TB] FAIL prio_req: got %b required 1", req);
            miscompares++;
        end
        tick();
        cp0_we = 1'b0;
        exc_code_in = 5'd0;
        read_reg(5'd14, rd);
        vectors++;
        if (rd !== 32'h0000_3040) begin
            $display("[TB] FAIL prio_epc_mtc0_lost: got %h required 00003040", rd);
            miscompares++;
        end
        read_reg(5'd13, rd);
        vectors++;
        if (rd !== 32'h0000_0400) begin
            $display("[TB] FAIL prio_int_over_exc: got %h required 00000400", rd);
            miscompares++;
        end
        hw_int = 6'b000000;
        mtc0(5'd12, 32'h0000_0000);
    endtask

    task automatic test_masking();
        hw_int = 6'b111111;
        // All IM bits, IE=0; reserved bits in the write must be dropped
        mtc0(5'd12, 32'hFFFF_FC00);
        #1;
        vectors++;
        if (req !== 1'b0) begin
            $display("[TB] FAIL mask_ie0_req: got %b required 0", req);
            miscompares++;
        end
        read_reg(5'd12, rd);
        vectors++;
        if (rd !== 32'h0000_FC00) begin
            $display("[TB] FAIL mask_sr_reserved: got %h required 0000fc00", rd);
            miscompares++;
        end
        read_reg(5'd13, rd);
        vectors++;
        if (rd !== 32'h0000_FC00) begin
            $display("[TB] FAIL mask_cause_ip: got %h required 0000fc00", rd);
            miscompares++;
        end
        mtc0(5'd13, 32'hFFFF_FFFF);
        read_reg(5'd13, rd);
        vectors++;
        if (rd !== 32'h0000_FC00) begin
            $display("[TB] FAIL cause_readonly: got %h required 0000fc00", rd);
            miscompares++;
        end
        mtc0(5'd12, 32'h0000_0001);
        #1;
        vectors++;
        if (req !== 1'b0) begin
            $display("[TB] FAIL mask_im0_req: got %b required 0", req);
            miscompares++;
        end
        read_reg(5'd3, rd);
        vectors++;
        if (rd !== 32'd0) begin
            $display("[TB] FAIL unmapped_read: got %h required 00000000", rd);
            miscompares++;
        end
        hw_int = 6'b000000;
        mtc0(5'd12, 32'h0000_0000);
    endtask

    task automatic test_reset_mid_handler();
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        vpc = 32'h0000_3050;
        tick();
        read_reg(5'd12, rd);
        vectors++;
        if (rd !== 32'h0000_0403) begin
            $display("[TB] FAIL midrst_in_handler: got %h required 00000403", rd);
            miscompares++;
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (req !== 1'b0 || epc_out !== 32'd0) begin
            $display("[TB] FAIL midrst_hold_outputs: req=%b epc_out=%h required req=0 epc_out=0", req, epc_out);
            miscompares++;
        end
        tick();
        hw_int = 6'b000000;
        reset = 1'b0;
        read_reg(5'd12, rd);
        vectors++;
        if (rd !== 32'd0) begin
            $display("[TB] FAIL midrst_sr: got %h required 00000000", rd);
            miscompares++;
        end
        read_reg(5'd13, rd);
        vectors++;
        if (rd !== 32'd0) begin
            $display("[TB] FAIL midrst_cause: got %h required 00000000", rd);
            miscompares++;
        end
        read_reg(5'd14, rd);
        vectors++;
        if (rd !== 32'd0) begin
            $display("[TB] FAIL midrst_epc: got %h required 00000000", rd);
            miscompares++;
        end
        vectors++;
        if (req !== 1'b0) begin
            $display("[TB] FAIL midrst_req: got %b required 0", req);
            miscompares++;
        end
    endtask

    // Main sequence
    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        cp0_addr = 5'd0;
        cp0_wdata = 32'd0;
        cp0_we = 1'b0;
        vpc = 32'd0;
        bd_in = 1'b0;
        exc_code_in = 5'd0;
        hw_int = 6'd0;
        eret = 1'b0;
        #1;
        test_reset();
        test_interrupt();
        test_exception_bd();
        test_eret();
        test_priority();
        test_masking();
        test_reset_mid_handler();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
